pipe_stage_buf: RTL and testbench

- Parametrised inter-stage pipeline buffer for the custom CPU (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries). It replaces the fixed-field stage registers.
- Carries an opaque DATA_W payload plus a TYPE_W instruction-type vector. The type vector is masked to zero whenever the entry is invalid.
- Uses a full valid/ready handshake on both sides, with an optional two-entry skid mode that registers the upstream ready and breaks the combinational ready path.
- Adds a synchronous flush for branch/exception recovery.

---
 rtl/pipe_stage_buf.sv | 109 ++++++++++
 tb/tb_pipe_stage_buf.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready handshake.
// Optional two-entry skid mode with registered in_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 128,
  parameter int TYPE_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TYPE_W-1:0] in_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TYPE_W-1:0] out_type,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TYPE_W-1:0] main_type_q, main_type_d;
  logic [TYPE_W-1:0] skid_type_q, skid_type_d;
  logic              accept;
  logic              pop;

  assign out_valid = (state_q != EMPTY);
  assign occ       = state_q;
  assign out_data  = main_data_q;
  assign out_type  = main_type_q & {TYPE_W{out_valid}};

  // rdy_q is low in reset; single-entry mode adds the pass-through term.
  assign in_ready = (SKID != 0) ? rdy_q
                                : (rdy_q & (~out_valid | out_ready));

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_type_d = main_type_q;
    skid_data_d = skid_data_q;
    skid_type_d = skid_type_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_type_d = in_type;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data_d = in_data;
            main_type_d = in_type;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_type_d = in_type;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_type_d = skid_type_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (SKID != 0) ? (state_d != TWO) : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      rdy_q       <= 1'b0;
      main_data_q <= '0;
      main_type_q <= '0;
      skid_data_q <= '0;
      skid_type_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      main_data_q <= main_data_d;
      main_type_q <= main_type_d;
      skid_data_q <= skid_data_d;
      skid_type_q <= skid_type_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid and single-entry instances
// driven in lockstep and compared against queue models.
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_type = '0;
  logic        out_ready = 1'b0;

  logic        rdy1, ov1, rdy0, ov0;
  logic [31:0] od1, od0;
  logic [7:0]  ot1, ot0;
  logic [1:0]  oc1, oc0;

  int passed = 0;
  int total  = 0;
  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .TYPE_W(8), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_type(in_type),
    .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_type(ot1), .occ(oc1)
  );

  pipe_stage_buf #(.DATA_W(32), .TYPE_W(8), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_type(in_type),
    .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_type(ot0), .occ(oc0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_dut(input string n, input int sz, input ent_t h,
                         input logic exp_rdy, input logic ov,
                         input logic rdy, input logic [31:0] od,
                         input logic [7:0] ot, input logic [1:0] oc);
    chk({n, ".occ"}, 32'(oc), 32'(sz));
    chk({n, ".out_valid"}, 32'(ov), 32'(sz != 0));
    chk({n, ".in_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({n, ".out_type"}, 32'(ot), (sz != 0) ? 32'(h.t) : 32'h0);
    if (sz != 0) chk({n, ".out_data"}, od, h.d);
  endtask

  // One cycle: drive at negedge, check, then advance the models.
  task automatic step(input logic iv, input logic [31:0] d,
                      input logic [7:0] t, input logic ordy,
                      input logic fl);
    logic r1, r0;
    ent_t e, h1, h0;
    @(negedge clk);
    in_valid = iv; in_data = d; in_type = t;
    out_ready = ordy; flush = fl;
    #1;
    e  = '{d: d, t: t};
    h1 = (q1.size() != 0) ? q1[0] : '0;
    h0 = (q0.size() != 0) ? q0[0] : '0;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || ordy;
    chk_dut("skid", q1.size(), h1, r1, ov1, rdy1, od1, ot1, oc1);
    chk_dut("single", q0.size(), h0, r0, ov0, rdy0, od0, ot0, oc0);
    if (ordy && q1.size() != 0) void'(q1.pop_front());
    if (ordy && q0.size() != 0) void'(q0.pop_front());
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (iv && r1) q1.push_back(e);
      if (iv && r0) q0.push_back(e);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready1", 32'(rdy1), 32'h0);
    chk("rst.in_ready0", 32'(rdy0), 32'h0);
    chk("rst.out_valid1", 32'(ov1), 32'h0);
    chk("rst.occ1", 32'(oc1), 32'h0);
    chk("rst.out_type1", 32'(ot1), 32'h0);
    chk("rst.out_data1", od1, 32'h0);
    chk("rst.occ0", 32'(oc0), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready1", 32'(rdy1), 32'h1);
    chk("post_rst.in_ready0", 32'(rdy0), 32'h1);

    for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 8'h01, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    step(1'b1, 32'hA, 8'h02, 1'b0, 1'b0);
    step(1'b1, 32'hB, 8'h04, 1'b0, 1'b0);
    step(1'b1, 32'hC, 8'h08, 1'b0, 1'b0);
    step(1'b1, 32'hC, 8'h08, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'hC, 8'h08, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 32'h55, 8'h24, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 32'h11, 8'h10, 1'b0, 1'b0);
    step(1'b1, 32'h22, 8'h20, 1'b0, 1'b0);
    step(1'b1, 32'h33, 8'h40, 1'b0, 1'b1);
    step(1'b1, 32'h44, 8'h80, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

    step(1'b1, 32'h77, 8'h01, 1'b0, 1'b0);
    step(1'b1, 32'h88, 8'h02, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.occ1", 32'(oc1), 32'h0);
    chk("midrst.out_type1", 32'(ot1), 32'h0);
    chk("midrst.in_ready1", 32'(rdy1), 32'h0);
    chk("midrst.occ0", 32'(oc0), 32'h0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 50; k++)
      step($urandom_range(0, 1) != 0, $urandom, 8'($urandom),
           $urandom_range(0, 1) != 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
